fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 14 +
 rtl/pcnext_logic.sv | 23 ++
 rtl/fetch_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and default constants for the MIPS-style instruction fetch path.
package mips_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          MAX_WAIT_DEFAULT = 16;

endpackage

// File: rtl/pcnext_logic.sv
// Combinational next-PC selection: jump over taken branch over sequential.
// All arithmetic wraps modulo 2^32.
module pcnext_logic (
    input  logic [31:0] pc,
    input  logic [25:0] instr,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] pcplus4,
    output logic [31:0] pcnext
);

    logic [31:0] branch_off;
    logic [31:0] jump_target;

    assign pcplus4     = pc + 32'd4;
    assign branch_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jump_target = {pcplus4[31:28], instr, 2'b00};

    assign pcnext = jump  ? jump_target :
                    pcsrc ? pcplus4 + branch_off :
                            pcplus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests the word at pc, holds it for the core until
// retire, then advances pc. A request unanswered for MAX_WAIT cycles locks in ERR.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        retire,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        fetch_err
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  instr_q;
    logic [7:0]   wait_q;
    logic         imem_req_q;
    logic         instr_valid_q;
    logic         fetch_err_q;

    pcnext_logic u_pcnext (
        .pc      (pc_q),
        .instr   (instr_q[25:0]),
        .pcsrc   (pcsrc),
        .jump    (jump),
        .pcplus4 (pcplus4),
        .pcnext  (pc_d)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= START;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            wait_q        <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            case (state_q)
                START: begin
                    state_q    <= REQ;
                    imem_req_q <= 1'b1;
                    wait_q     <= '0;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        state_q       <= VALID;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q     <= ERR;
                        imem_req_q  <= 1'b0;
                        fetch_err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                VALID: begin
                    if (retire) begin
                        pc_q          <= pc_d;
                        state_q       <= REQ;
                        instr_valid_q <= 1'b0;
                        imem_req_q    <= 1'b1;
                        wait_q        <= '0;
                    end
                end
                default: begin
                    state_q <= ERR;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign fetch_err   = fetch_err_q;

endmodule
